pending_prio_encoder: RTL and testbench

Parametrised, clocked N-to-log2(N) priority encoder with a sticky request register. It captures one-hot or multi-hot request vectors, holds every request until a consumer acknowledges it, and presents one pending index per cycle. Two selection modes are supported: fixed priority and round-robin. The block sits between raw request/event lines and a single serial consumer such as a display, counter or interrupt handler.

---
 rtl/pending_prio_encoder_if.sv | 34 +++
 rtl/pending_prio_encoder.sv | 100 ++++++++++
 tb/tb_pending_prio_encoder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pending_prio_encoder_if.sv
// rtl/pending_prio_encoder_if.sv - request/acknowledge bus of the sticky priority encoder
//
// Signals:
//   CLR    master->slave  synchronous clear of all state (active-high)
//   EN     master->slave  capture enable for DATA
//   DATA   master->slave  request vector, bit i requests index i
//   ACK    master->slave  consumer accepts the index currently on out
//   out    slave->master  selected pending index (registered)
//   VALID  slave->master  at least one request pending
//   MULTI  slave->master  two or more requests pending
//   OVF    slave->master  sticky: a request hit a line that was already pending
interface pending_prio_encoder_if #(
  parameter int N = 8,
  parameter int W = 3
);
  logic         CLR;
  logic         EN;
  logic [N-1:0] DATA;
  logic         ACK;
  logic [W-1:0] out;
  logic         VALID;
  logic         MULTI;
  logic         OVF;

  modport master (
    output CLR, EN, DATA, ACK,
    input  out, VALID, MULTI, OVF
  );

  modport slave (
    input  CLR, EN, DATA, ACK,
    output out, VALID, MULTI, OVF
  );
endinterface

// File: rtl/pending_prio_encoder.sv
// rtl/pending_prio_encoder.sv - sticky N-to-log2(N) priority encoder, fixed or round-robin
//
// Ports:
//   CP   clock, all state changes on the rising edge
//   CR   asynchronous active-low reset
//   bus  pending_prio_encoder_if.slave: CLR/EN/DATA/ACK in, out/VALID/MULTI/OVF out
// Parameters:
//   N   number of request lines (2..32)
//   W   index width, ceil(log2(N))
//   RR  0 = fixed priority (highest index wins), 1 = round-robin
module pending_prio_encoder #(
  parameter int N  = 8,
  parameter int W  = 3,
  parameter int RR = 0
) (
  input  logic                  CP,
  input  logic                  CR,
  pending_prio_encoder_if.slave bus
);

  localparam logic [W-1:0] PTR_INIT = W'(N - 1);
  localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] pend_q;
  logic [W-1:0] ptr_q;
  logic [W-1:0] out_q;
  logic         valid_q;
  logic         multi_q;
  logic         ovf_q;

  logic [N-1:0] served;
  logic [N-1:0] captured;
  logic [N-1:0] pend_next;
  logic [W-1:0] ptr_next;
  logic [W-1:0] sel_next;
  logic         ovf_set;
  logic         take;

  // A retirement only happens when something is actually being shown;
  // ACK against an empty encoder has no effect on state.
  assign take     = valid_q & bus.ACK;
  assign served   = take ? (ONE << out_q) : '0;
  assign captured = bus.EN ? bus.DATA : '0;
  assign pend_next = (pend_q & ~served) | captured;
  assign ptr_next  = take ? out_q : ptr_q;

  // A bit retired and re-requested on the same edge is a fresh request,
  // so only bits that remain pending count as overflow.
  assign ovf_set = |(captured & pend_q & ~served);

  // Selection runs on the next pending state so out always matches VALID.
  always_comb begin
    sel_next = '0;
    if (RR == 0) begin
      for (int i = 0; i < N; i++) begin
        if (pend_next[i]) sel_next = W'(i);
      end
    end else begin
      // Scan downward over the rotated order so the last hit is the first
      // set index at or after ptr_next+1, wrapping from N-1 to 0.
      for (int k = N - 1; k >= 0; k--) begin
        int idx;
        idx = (int'(ptr_next) + 1 + k) % N;
        if (pend_next[idx]) sel_next = W'(idx);
      end
    end
  end

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      pend_q  <= '0;
      ptr_q   <= PTR_INIT;
      out_q   <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (bus.CLR) begin
      pend_q  <= '0;
      ptr_q   <= PTR_INIT;
      out_q   <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q  <= pend_next;
      ptr_q   <= ptr_next;
      out_q   <= sel_next;
      valid_q <= |pend_next;
      // Clearing the lowest set bit leaves something only if two or more were set.
      multi_q <= |(pend_next & (pend_next - ONE));
      ovf_q   <= ovf_q | ovf_set;
    end
  end

  assign bus.out   = out_q;
  assign bus.VALID = valid_q;
  assign bus.MULTI = multi_q;
  assign bus.OVF   = ovf_q;

endmodule

// File: tb/tb_pending_prio_encoder.sv
// tb/tb_pending_prio_encoder.sv - scoreboard bench for fixed-priority and round-robin encoders
module tb_pending_prio_encoder;

  logic cp = 1'b0;
  logic cr;

  always #5 cp = ~cp;

  pending_prio_encoder_if #(.N(8), .W(3)) ifa ();
  pending_prio_encoder_if #(.N(8), .W(3)) ifb ();

  pending_prio_encoder #(.N(8), .W(3), .RR(0)) u_fix (.CP(cp), .CR(cr), .bus(ifa));
  pending_prio_encoder #(.N(8), .W(3), .RR(1)) u_rr  (.CP(cp), .CR(cr), .bus(ifb));

  typedef struct {
    int         dut;
    string      name;
    logic [2:0] o;
    logic       v;
    logic       m;
    logic       f;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  event chk_ev;

  task automatic cmp(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: after each clock edge (or an explicit async-check event) pop
  // every expectation issued for that point and compare against the DUT.
  initial begin
    forever begin
      @(posedge cp or chk_ev);
      #2;
      while (q.size() > 0) begin
        exp_t e;
        logic [2:0] ao;
        logic av, am, af;
        e = q.pop_front();
        if (e.dut == 0) begin
          ao = ifa.out; av = ifa.VALID; am = ifa.MULTI; af = ifa.OVF;
        end else begin
          ao = ifb.out; av = ifb.VALID; am = ifb.MULTI; af = ifb.OVF;
        end
        cmp({e.name, (e.dut == 0) ? "/fix/out" : "/rr/out"}, int'(ao), int'(e.o));
        cmp({e.name, (e.dut == 0) ? "/fix/valid" : "/rr/valid"}, int'(av), int'(e.v));
        cmp({e.name, (e.dut == 0) ? "/fix/multi" : "/rr/multi"}, int'(am), int'(e.m));
        cmp({e.name, (e.dut == 0) ? "/fix/ovf" : "/rr/ovf"}, int'(af), int'(e.f));
      end
    end
  end

  task automatic drive(logic clr, logic en, logic [7:0] data, logic ack);
    ifa.CLR = clr; ifa.EN = en; ifa.DATA = data; ifa.ACK = ack;
    ifb.CLR = clr; ifb.EN = en; ifb.DATA = data; ifb.ACK = ack;
  endtask

  task automatic expect2(string name,
                         int o0, logic v0, logic m0, logic f0,
                         int o1, logic v1, logic m1, logic f1);
    exp_t e;
    e.name = name;
    e.dut = 0; e.o = 3'(o0); e.v = v0; e.m = m0; e.f = f0; q.push_back(e);
    e.dut = 1; e.o = 3'(o1); e.v = v1; e.m = m1; e.f = f1; q.push_back(e);
  endtask

  // One clock: inputs already driven at a falling edge, expectations queued,
  // the monitor checks just after the rising edge.
  task automatic step(string name, logic clr, logic en, logic [7:0] data, logic ack,
                      int o0, logic v0, logic m0, logic f0,
                      int o1, logic v1, logic m1, logic f1);
    drive(clr, en, data, ack);
    expect2(name, o0, v0, m0, f0, o1, v1, m1, f1);
    @(negedge cp);
  endtask

  initial begin
    cr = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge cp);
    #1;
    expect2("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    ->chk_ev;
    @(negedge cp);
    cr = 1'b1;

    // basic capture
    step("cap01",   0, 1, 8'h01, 0,  0, 1, 0, 0,  0, 1, 0, 0);
    step("cap01ak", 0, 0, 8'h00, 1,  0, 0, 0, 0,  0, 0, 0, 0);

    // fixed priority on 81 (rr pointer is 0 here)
    step("p81",     0, 1, 8'h81, 0,  7, 1, 1, 0,  7, 1, 1, 0);
    step("p81a1",   0, 0, 8'h00, 1,  0, 1, 0, 0,  0, 1, 0, 0);
    step("p81a2",   0, 0, 8'h00, 1,  0, 0, 0, 0,  0, 0, 0, 0);
    step("p81a3",   0, 0, 8'h00, 1,  0, 0, 0, 0,  0, 0, 0, 0);

    // round-robin from a cleared pointer
    step("clr0",    1, 0, 8'h00, 0,  0, 0, 0, 0,  0, 0, 0, 0);
    step("r89",     0, 1, 8'h89, 0,  7, 1, 1, 0,  0, 1, 1, 0);
    step("r89a1",   0, 0, 8'h00, 1,  3, 1, 1, 0,  3, 1, 1, 0);
    step("r89a2",   0, 0, 8'h00, 1,  0, 1, 0, 0,  7, 1, 0, 0);
    step("r89a3",   0, 0, 8'h00, 1,  0, 0, 0, 0,  0, 0, 0, 0);
    step("r09",     0, 1, 8'h09, 0,  3, 1, 1, 0,  0, 1, 1, 0);
    step("r09a1",   0, 0, 8'h00, 1,  0, 1, 0, 0,  3, 1, 0, 0);
    step("r09a2",   0, 0, 8'h00, 1,  0, 0, 0, 0,  0, 0, 0, 0);

    // overflow, then sticky
    step("ov1",     0, 1, 8'h04, 0,  2, 1, 0, 0,  2, 1, 0, 0);
    step("ov2",     0, 1, 8'h04, 0,  2, 1, 0, 1,  2, 1, 0, 1);
    step("ovhold",  0, 0, 8'h00, 0,  2, 1, 0, 1,  2, 1, 0, 1);
    step("ovack",   0, 0, 8'h00, 1,  0, 0, 0, 1,  0, 0, 0, 1);
    step("clr1",    1, 0, 8'h00, 0,  0, 0, 0, 0,  0, 0, 0, 0);

    // served and re-requested on the same edge is not an overflow
    step("rq1",     0, 1, 8'h04, 0,  2, 1, 0, 0,  2, 1, 0, 0);
    step("rq2",     0, 1, 8'h04, 1,  2, 1, 0, 0,  2, 1, 0, 0);
    step("rq3",     0, 0, 8'h00, 1,  0, 0, 0, 0,  0, 0, 0, 0);

    // async reset between edges (rr pointer is 2 here)
    step("pF0",     0, 1, 8'hF0, 0,  7, 1, 1, 0,  4, 1, 1, 0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    cr = 1'b0;
    expect2("async", 0, 0, 0, 0, 0, 0, 0, 0);
    ->chk_ev;
    repeat (2) @(negedge cp);
    cr = 1'b1;
    step("post0",   0, 0, 8'h00, 0,  0, 0, 0, 0,  0, 0, 0, 0);
    step("post1",   0, 0, 8'h00, 1,  0, 0, 0, 0,  0, 0, 0, 0);

    // CLR wins over EN/DATA/ACK with pending 22 and OVF set
    step("p22",     0, 1, 8'h22, 0,  5, 1, 1, 0,  1, 1, 1, 0);
    step("p22ov",   0, 1, 8'h02, 0,  5, 1, 1, 1,  1, 1, 1, 1);
    step("clrpri",  1, 1, 8'h01, 1,  0, 0, 0, 0,  0, 0, 0, 0);
    step("p03",     0, 1, 8'h03, 0,  1, 1, 1, 0,  0, 1, 1, 0);

    drive(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge cp);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d left expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
